// File: rtl/aes_inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns engine with valid/ready in/out handshakes.
// CPC columns are transformed per BUSY cycle; in_bypass skips the transform for the last round.
module aes_inv_mix_columns_seq #(
    parameter int unsigned CPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NCOL  = 4;
    localparam int unsigned COLW  = 32;
    localparam int unsigned STW   = NCOL * COLW;
    localparam int unsigned CNTW  = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] col_q, col_d;
    logic [STW-1:0]  work_q, work_d;
    logic            byp_q, byp_d;
    logic [STW-1:0]  result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the 0e/0b/0d/09 circulant, multiples built from xtime chains.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [3:0][7:0] s;
        logic [3:0][7:0] m9, mb, md, me;
        logic [7:0]      x2, x4, x8;
        s = c;
        for (int i = 0; i < 4; i++) begin
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        // s[3] is row 0 (MS byte)
        return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
                m9[3] ^ me[2] ^ mb[1] ^ md[0],
                md[3] ^ m9[2] ^ me[1] ^ mb[0],
                mb[3] ^ md[2] ^ m9[1] ^ me[0]};
    endfunction

    // Transform columns col .. col+CPC-1 in place; column 0 occupies the MS word.
    function automatic logic [STW-1:0] apply_cols(input logic [STW-1:0] w,
                                                  input logic [CNTW-1:0] col,
                                                  input logic byp);
        logic [NCOL-1:0][COLW-1:0] wp;
        logic [CNTW-1:0]           pos;
        wp = w;
        for (int k = 0; k < int'(CPC); k++) begin
            pos     = 2'd3 - (col + 2'(k));
            wp[pos] = byp ? wp[pos] : inv_col(wp[pos]);
        end
        return wp;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            work_q      <= '0;
            byp_q       <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            byp_q       <= byp_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        logic [STW-1:0] proc;
        logic           last;
        state_d  = state_q;
        col_d    = col_q;
        work_d   = work_q;
        byp_d    = byp_q;
        result_d = result_q;
        proc     = apply_cols(work_q, col_q, byp_q);
        last     = ((3'(col_q) + 3'(CPC)) == 3'd4);

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_state;
                    byp_d   = in_bypass;
                    col_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d = proc;
                col_d  = col_q + 2'(CPC);
                if (last) begin
                    result_d = proc;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags registered from the next state so they track state_q exactly.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_BUSY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = result_q;

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Self-checking bench for aes_inv_mix_columns_seq: known answers at CPC 1/2/4, stall, reset and random traffic.
// Reference is a generic GF(2^8) matrix product; forward MixColumns is used to confirm invertibility.
module tb_aes_inv_mix_columns_seq;

    localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam int NBLK = 1000;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         iv  [3];
    logic         orr [3];
    logic         ir  [3];
    logic         ov  [3];
    logic         bz  [3];
    logic [127:0] os  [3];

    int n_checks;
    int n_fail;

    aes_inv_mix_columns_seq #(.CPC(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
        .in_bypass(in_bypass), .out_valid(ov[0]), .out_ready(orr[0]), .out_state(os[0]), .busy(bz[0]));
    aes_inv_mix_columns_seq #(.CPC(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
        .in_bypass(in_bypass), .out_valid(ov[1]), .out_ready(orr[1]), .out_state(os[1]), .busy(bz[1]));
    aes_inv_mix_columns_seq #(.CPC(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
        .in_bypass(in_bypass), .out_valid(ov[2]), .out_ready(orr[2]), .out_state(os[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column; base holds row 0 coefficients, MS byte first.
    function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [31:0] base);
        logic [127:0] r;
        logic [7:0]   acc, cf, sb;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    cf  = base[31 - 8 * ((j - row + 4) % 4) -: 8];
                    sb  = s[127 - 32 * c - 8 * j -: 8];
                    acc ^= gf_mul(cf, sb);
                end
                r[127 - 32 * c - 8 * row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] s);
        return mat_apply(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_ref(input logic [127:0] s);
        return mat_apply(s, 32'h02030101);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int u);
        int cnt;
        cnt = 0;
        while (!ir[u] && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq("ready_wait", 128'(ir[u]), 128'(1));
    endtask

    task automatic wait_out(input int u, output int lat);
        lat = 0;
        while (!ov[u] && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int u);
        orr[u] = 1'b1;
        tick();
        orr[u] = 1'b0;
    endtask

    task automatic run_kat(input int u, input int exp_lat);
        int lat;
        wait_ready(u);
        in_state  = KAT_IN;
        in_bypass = 1'b0;
        iv[u]     = 1'b1;
        tick();
        iv[u]     = 1'b0;
        in_state  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_bypass = 1'b1;
        check_eq("kat_busy", 128'(bz[u]), 128'(1));
        wait_out(u, lat);
        check_eq("kat_latency", 128'(lat), 128'(exp_lat));
        check_eq("kat_const", os[u], KAT_OUT);
        check_eq("kat_model", os[u], inv_ref(KAT_IN));
        drain(u);
        check_eq("kat_release_valid", 128'(ov[u]), 128'(0));
        check_eq("kat_release_ready", 128'(ir[u]), 128'(1));
        check_eq("kat_hold_after", os[u], KAT_OUT);
    endtask

    logic [127:0] exp_q[$];
    logic [127:0] src_q[$];
    logic         byp_qq[$];
    bit           abort;

    initial begin
        logic [127:0] x, y, z, c6;
        int lat;
        n_checks  = 0;
        n_fail    = 0;
        abort     = 1'b0;
        rst_n     = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        for (int u = 0; u < 3; u++) begin
            iv[u]  = 1'b0;
            orr[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_out_valid", 128'(ov[u]), 128'(0));
            check_eq("rst_out_state", os[u], 128'(0));
            check_eq("rst_busy", 128'(bz[u]), 128'(0));
            check_eq("rst_in_ready", 128'(ir[u]), 128'(0));
        end
        rst_n = 1'b1;
        tick();

        run_kat(0, 4);
        run_kat(1, 2);
        run_kat(2, 1);

        // Bypass block, stalled output, in_valid held with a different block.
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        y = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_ready(0);
        in_state  = x;
        in_bypass = 1'b1;
        iv[0]     = 1'b1;
        tick();
        in_state  = y;
        in_bypass = 1'b0;
        check_eq("byp_old_out_kept", os[0], KAT_OUT);
        wait_out(0, lat);
        check_eq("byp_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 5; i++) begin
            check_eq("byp_stall_state", os[0], x);
            check_eq("byp_stall_valid", 128'(ov[0]), 128'(1));
            check_eq("byp_stall_ready", 128'(ir[0]), 128'(0));
            tick();
        end
        orr[0] = 1'b1;
        tick();
        orr[0] = 1'b0;
        check_eq("byp_release_valid", 128'(ov[0]), 128'(0));
        check_eq("byp_no_accept_in_done", 128'(ir[0]), 128'(1));
        tick();
        iv[0] = 1'b0;
        check_eq("next_accepted_busy", 128'(bz[0]), 128'(1));
        wait_out(0, lat);
        check_eq("next_latency", 128'(lat), 128'(4));
        check_eq("next_state", os[0], inv_ref(y));
        drain(0);

        // Reset on the second BUSY cycle.
        z = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_ready(0);
        in_state  = z;
        in_bypass = 1'b0;
        iv[0]     = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 128'(ov[0]), 128'(0));
        check_eq("midrst_out_state", os[0], 128'(0));
        check_eq("midrst_busy", 128'(bz[0]), 128'(0));
        check_eq("midrst_in_ready", 128'(ir[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        c6 = {16{8'hc6}};
        wait_ready(0);
        in_state = c6;
        iv[0]    = 1'b1;
        tick();
        iv[0] = 1'b0;
        wait_out(0, lat);
        check_eq("postrst_latency", 128'(lat), 128'(4));
        check_eq("postrst_c6", os[0], c6);
        drain(0);

        // Random back-to-back traffic with gaps and backpressure.
        fork
            begin : producer
                logic [127:0] blk;
                logic         bp, acc;
                int           waited, gap;
                for (int i = 0; i < NBLK && !abort; i++) begin
                    gap = int'($urandom_range(0, 2));
                    for (int g = 0; g < gap; g++) tick();
                    blk       = {$urandom(), $urandom(), $urandom(), $urandom()};
                    bp        = ($urandom_range(0, 3) == 0);
                    in_state  = blk;
                    in_bypass = bp;
                    iv[0]     = 1'b1;
                    waited    = 0;
                    do begin
                        acc = ir[0];
                        tick();
                        waited++;
                    end while (!acc && waited < 200);
                    iv[0] = 1'b0;
                    if (!acc) begin
                        check_eq("rand_accept_timeout", 128'(acc), 128'(1));
                        abort = 1'b1;
                    end else begin
                        src_q.push_back(blk);
                        byp_qq.push_back(bp);
                        exp_q.push_back(bp ? blk : inv_ref(blk));
                    end
                end
            end
            begin : consumer
                logic [127:0] e, s;
                logic         b, r;
                int           got, cyc;
                got = 0;
                cyc = 0;
                while (got < NBLK && cyc < 60000 && !abort) begin
                    r      = 1'($urandom_range(0, 1));
                    orr[0] = r;
                    if (ov[0] && r) begin
                        if (exp_q.size() == 0) begin
                            check_eq("rand_unexpected_out", os[0], 128'(0));
                            got = NBLK;
                        end else begin
                            e = exp_q.pop_front();
                            s = src_q.pop_front();
                            b = byp_qq.pop_front();
                            check_eq("rand_out", os[0], e);
                            if (!b) check_eq("rand_fwd_roundtrip", fwd_ref(os[0]), s);
                            got++;
                        end
                    end
                    tick();
                    cyc++;
                end
                orr[0] = 1'b0;
                check_eq("rand_count", 128'(got), 128'(NBLK));
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
